alu_rf_sequencer: RTL and testbench
===================================

Name: alu_rf_sequencer

Overview:
Initiator-side controller for the ALU + register-file datapath. It accepts 32-bit MIPS-format instruction words over a valid/ready handshake and decodes them. It then drives the datapath's read, function and ALU-op inputs, captures the ALU result and Zero flag, performs the register write-back, and returns the result over a second valid/ready handshake. It replaces hand-driven stimulus as the agent that sequences the datapath.

Parameters:
- WB_DISABLE_R0, 1, when 1, suppresses write-back when the destination register is 0.
- BEQ_OPCODE, 6'h04, opcode treated as a compare (ALUOp 01, no write-back).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  32  op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0].
- Read1  out  5  datapath read port 1 address (rs).
- Read2  out  5  datapath read port 2 address (rt).
- FuncCode  out  4  funct[3:0], passed through unchanged.
- ALUOp  out  2  2'b10 for R-type (op==0), 2'b01 for BEQ_OPCODE.
- WriteReg  out  5  write-back address (rd).
- RegWrite  out  2  2'b01 during the write-back cycle, else 2'b00.
- WriteData  out  32  captured ALU result.
- ALUOut  in  32  datapath ALU result.
- Zero  in  2  datapath zero flag; only bit 0 is used.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  captured ALUOut.
- out_zero  out  1  captured Zero[0].
- out_err  out  1  instruction had an unsupported opcode.

Behaviour:
- Reset values: all outputs are 0, except in_ready=1. State is IDLE.
- States: IDLE, ISSUE, EXEC, WB, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_instr and go to ISSUE. in_ready drops on the next cycle.
- ISSUE:
  - Drive registered Read1=rs, Read2=rt, FuncCode=funct[3:0] and ALUOp; hold them until the return to IDLE.
  - Unsupported opcode (neither 0 nor BEQ_OPCODE): ALUOp=00, set err, skip directly to RESP.
  - Otherwise go to EXEC.
- EXEC:
  - The datapath settles combinationally during ISSUE→EXEC.
  - Capture ALUOut into out_data/WriteData and Zero[0] into out_zero at the end of EXEC.
  - Go to WB.
- WB:
  - RegWrite=2'b01 and WriteReg=rd for exactly one cycle.
  - Write-back is suppressed (RegWrite stays 00, but the state is still traversed) for a compare opcode, or when rd==0 with WB_DISABLE_R0=1.
  - Go to RESP.
- RESP:
  - out_valid=1, with out_data/out_zero/out_err stable.
  - Hold until out_ready; on out_valid&&out_ready, clear out_valid and go to IDLE.
  - No new instruction is accepted until the cycle after the handshake.
- Latency: the accept edge to out_valid asserted is 4 clocks for a legal instruction and 2 clocks for an illegal one. Throughput is at most one instruction per 5 clocks.
- out_ready asserted before out_valid has no effect. in_valid while busy is ignored; the producer must hold the instruction.
- Reset mid-operation: the next edge returns to IDLE and forces RegWrite=00 and out_valid=0. Any pending write-back is dropped and the latched instruction is discarded.
- Read-after-write: the write-back occurs before the next ISSUE, so back-to-back dependent instructions read the updated value.

Optional Feature:
- Macro: ALU_SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt [31:0]. It increments by 1 on each out_valid&&out_ready handshake with out_err=0, wraps 0xFFFFFFFF→0, and resets to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with in_valid=1 held → in_ready=1, out_valid=0, RegWrite=00. No accept occurs until the cycle after rst falls.
- Datapath model has R5=0x55555555, R10=0xAAAAAAAA; issue instr 0x00AA5020 (rs=5 rt=10 rd=10 funct=0x20) with ALUOut modelled as 0xFFFFFFFF. Expected: Read1=5, Read2=10, FuncCode=0000, ALUOp=10; one RegWrite=01 pulse with WriteReg=10, WriteData=0xFFFFFFFF; out_valid at accept+4 with out_data=0xFFFFFFFF.
- BEQ 0x10A50000 with model Zero=01, ALUOut=0 → ALUOp=01, no RegWrite pulse, out_zero=1.
- Opcode 0x3F → out_err=1 and out_valid at accept+2; no RegWrite; with the macro defined, retire_cnt is unchanged.
- out_ready held low for 10 cycles in RESP → out_valid and out_data stay stable and in_ready=0; release gives exactly one handshake, then in_ready=1 the following cycle.
- Assert rst during WB → RegWrite=00 on the next edge, return to IDLE, no out_valid; the next instruction completes normally.

Source files
------------

// File: rtl/alu_rf_sequencer.sv
// Sequencer for the ALU + register-file datapath: accepts MIPS R-type/BEQ words and drives the datapath.
// Defining ALU_SEQ_RETIRE_CNT_EN adds the retire_cnt output (successful responses counter).
module alu_rf_sequencer #(
  parameter bit         WB_DISABLE_R0 = 1'b1,
  parameter logic [5:0] BEQ_OPCODE    = 6'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  Read1,
  output logic [4:0]  Read2,
  output logic [3:0]  FuncCode,
  output logic [1:0]  ALUOp,
  output logic [4:0]  WriteReg,
  output logic [1:0]  RegWrite,
  output logic [31:0] WriteData,
  input  logic [31:0] ALUOut,
  input  logic [1:0]  Zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic        out_err
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, EXEC, WB, RESP} state_t;

  state_t     state, state_nxt;
  logic [4:0] rd_q;
  logic       wb_en;
  logic       err;
  logic [5:0] op;
  logic       unused_bits;

  assign op          = in_instr[31:26];
  assign unused_bits = ^{in_instr[10:4], Zero[1]};
  assign out_data    = WriteData;
  assign out_err     = err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = err ? RESP : EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == RESP);
    RegWrite  = (state == WB && wb_en) ? 2'b01 : 2'b00;
    WriteReg  = (state == WB) ? rd_q : 5'd0;
  end

  // Decode happens at the accept edge so the datapath sees stable operands for all of ISSUE and EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      Read1     <= '0;
      Read2     <= '0;
      FuncCode  <= '0;
      ALUOp     <= '0;
      rd_q      <= '0;
      wb_en     <= 1'b0;
      err       <= 1'b0;
      WriteData <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          Read1     <= in_instr[25:21];
          Read2     <= in_instr[20:16];
          FuncCode  <= in_instr[3:0];
          rd_q      <= in_instr[15:11];
          WriteData <= '0;
          out_zero  <= 1'b0;
          if (op == 6'd0) begin
            ALUOp <= 2'b10;
            err   <= 1'b0;
            wb_en <= !(WB_DISABLE_R0 && in_instr[15:11] == 5'd0);
          end else if (op == BEQ_OPCODE) begin
            ALUOp <= 2'b01;
            err   <= 1'b0;
            wb_en <= 1'b0;
          end else begin
            ALUOp <= 2'b00;
            err   <= 1'b1;
            wb_en <= 1'b0;
          end
        end
        EXEC: begin
          WriteData <= ALUOut;
          out_zero  <= Zero[0];
        end
        RESP: if (out_ready) begin
          Read1    <= '0;
          Read2    <= '0;
          FuncCode <= '0;
          ALUOp    <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                    retire_cnt <= '0;
    else if (state == RESP && out_ready && !err) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Randomized bench for alu_rf_sequencer: a behavioural datapath drives ALUOut/Zero, and a
// transaction-level reference (architectural register file + cycle budgets) predicts every response.
module tb_alu_rf_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [31:0] in_instr, WriteData, ALUOut, out_data;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [3:0]  FuncCode;
  logic [1:0]  ALUOp, RegWrite, Zero;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] exp_retire = '0;
`endif

  logic [31:0] rf     [32];
  logic [31:0] ref_rf [32];
  logic        zero_junk = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  alu_rf_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .Read1(Read1), .Read2(Read2), .FuncCode(FuncCode), .ALUOp(ALUOp), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .WriteData(WriteData), .ALUOut(ALUOut), .Zero(Zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_err(out_err)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  function automatic logic [31:0] alu(input logic [1:0] op, input logic [3:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'b10: case (fn)
        4'h0:    r = a + b;
        4'h2:    r = a - b;
        4'h4:    r = a & b;
        4'h5:    r = a | b;
        4'ha:    r = {31'd0, $signed(a) < $signed(b)};
        default: r = a ^ b;
      endcase
      2'b01:   r = a - b;
      default: r = 32'hDEADBEEF;
    endcase
    return r;
  endfunction

  // Datapath model; Zero[1] carries noise the sequencer must ignore.
  always_comb begin
    ALUOut = alu(ALUOp, FuncCode, rf[Read1], rf[Read2]);
    Zero   = {zero_junk, ALUOut == 32'd0};
  end

  // A write cut short by reset is treated as aborted.
  always @(posedge clk) begin
    zero_junk <= 1'($urandom_range(0, 1));
    if (!rst && RegWrite == 2'b01) rf[WriteReg] <= WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run(input logic [31:0] instr, input int hold, input bit early_ready);
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  exp_op;
    logic [31:0] exp_res, d0;
    bit          legal, exp_wb, seen, stable;
    int          k, pulses, exp_lat;
    op      = instr[31:26];
    rs      = instr[25:21];
    rt      = instr[20:16];
    rd      = instr[15:11];
    legal   = (op == 6'd0) || (op == 6'h04);
    exp_op  = (op == 6'd0) ? 2'b10 : (op == 6'h04) ? 2'b01 : 2'b00;
    exp_res = alu(exp_op, instr[3:0], ref_rf[rs], ref_rf[rt]);
    exp_wb  = (op == 6'd0) && (rd != 5'd0);
    exp_lat = legal ? 4 : 2;

    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_instr  = instr;
    out_ready = early_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = $urandom;
    k = 0; pulses = 0; seen = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("read1", 32'(Read1), 32'(rs));
        chk("read2", 32'(Read2), 32'(rt));
        chk("funccode", 32'(FuncCode), 32'(instr[3:0]));
        chk("aluop", 32'(ALUOp), 32'(exp_op));
        chk("busy_in_ready", 32'(in_ready), 32'd0);
      end
      if (RegWrite != 2'b00) begin
        pulses++;
        chk("wb_regwrite", 32'(RegWrite), 32'd1);
        chk("wb_reg", 32'(WriteReg), 32'(rd));
        chk("wb_data", WriteData, exp_res);
      end
      if (out_valid) seen = 1'b1;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("wb_pulses", 32'(pulses), 32'(exp_wb));
    chk("out_err", 32'(out_err), 32'(!legal));
    if (legal) begin
      chk("out_data", out_data, exp_res);
      chk("out_zero", 32'(out_zero), 32'(exp_res == 32'd0));
    end
    d0 = out_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== d0 || in_ready || RegWrite != 2'b00) stable = 1'b0;
    end
    if (hold > 0) chk("resp_hold", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (exp_wb) ref_rf[rd] = exp_res;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    if (legal) exp_retire = exp_retire + 32'd1;
`endif
    @(negedge clk);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, exp_retire);
`endif
  endtask

  logic [31:0] v, ins;
  logic [5:0]  rop;
  logic [5:0]  fsel [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
  int          r, hold;

  initial begin
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'd0 : $urandom;
      rf[i] = v;
      ref_rf[i] = v;
    end
    rf[5]  = 32'h55555555; ref_rf[5]  = 32'h55555555;
    rf[10] = 32'hAAAAAAAA; ref_rf[10] = 32'hAAAAAAAA;

    // Reset with a pending instruction on the input: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00AA5020; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_read1", 32'(Read1), 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b0;

    run(32'h00AA5020, 0, 1'b0);   // add: 0x55555555 + 0xAAAAAAAA
    run(32'h10A50000, 0, 1'b0);   // compare R5 with itself -> Zero
    run(32'hFC000000, 2, 1'b0);   // unsupported opcode
    run(32'h01095822, 10, 1'b0);  // long back-pressure in RESP
    run(32'h00000020, 0, 1'b1);   // rd=0: write-back suppressed

    // Reset during WB drops the write and the response.
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00642820;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wb_before_rst", 32'(RegWrite), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wb_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wb_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wb_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    run(32'h00A62820, 0, 1'b0);   // reads R5 again: must still hold the pre-reset value

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      rop = 6'd0;
      else if (r < 8) rop = 6'h04;
      else            rop = 6'($urandom_range(5, 63));
      ins  = {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom), fsel[$urandom_range(0, 5)]};
      hold = $urandom_range(0, 3);
      run(ins, hold, (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
